// File: rtl/sdsu_bus_arbiter.sv
// rtl/sdsu_bus_arbiter.sv - round-robin arbiter sharing one SDSU bus slave among NM masters
// Optional slave-ready timeout is compiled in with SDSU_ARB_TIMEOUT_EN.
module sdsu_bus_arbiter #(
    parameter int NM      = 4,
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM-1:0]    m_valid,
    input  logic [NM*AW-1:0] m_waddr,
    input  logic [NM*DW-1:0] m_wdata,
    input  logic [NM*AW-1:0] m_raddr,
    output logic [DW-1:0]    m_rdata,
    output logic [NM-1:0]    m_ready,
    output logic [NM-1:0]    m_err,
    output logic [NM-1:0]    grant,
    output logic             s_valid,
    output logic [AW-1:0]    s_waddr,
    output logic [DW-1:0]    s_wdata,
    output logic [AW-1:0]    s_raddr,
    input  logic [DW-1:0]    s_rdata,
    input  logic             s_ready
);

    localparam int PW = (NM > 1) ? $clog2(NM) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (NM < 2 || NM > 8 || TIMEOUT < 1) begin : g_param_check
        $error("sdsu_bus_arbiter: NM must be 2..8 and TIMEOUT >= 1");
    end

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] rr_q, rr_d;
    logic [PW-1:0] sel_q, sel_d;
    logic [NM-1:0] grant_q, grant_d;
    logic          s_valid_q, s_valid_d;
    logic [AW-1:0] s_waddr_q, s_waddr_d;
    logic [DW-1:0] s_wdata_q, s_wdata_d;
    logic [AW-1:0] s_raddr_q, s_raddr_d;
    logic [DW-1:0] m_rdata_q, m_rdata_d;
    logic [NM-1:0] m_ready_q, m_ready_d;
    logic [NM-1:0] m_err_q, m_err_d;
    logic          pick_found;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] rr_after;
    int            cand;

`ifdef SDSU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // First requester at or after rr_q, wrapping modulo NM.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 0; k < NM; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= NM) begin
                cand = cand - NM;
            end
            if (!pick_found && m_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(cand);
            end
        end
    end

    assign rr_after = (sel_q == PW'(NM - 1)) ? '0 : sel_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        s_valid_d = s_valid_q;
        s_waddr_d = s_waddr_q;
        s_wdata_d = s_wdata_q;
        s_raddr_d = s_raddr_q;
        m_rdata_d = m_rdata_q;
        m_ready_d = '0;
        m_err_d   = '0;
`ifdef SDSU_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    sel_d     = pick_idx;
                    grant_d   = NM'(1) << pick_idx;
                    s_valid_d = 1'b1;
                    s_waddr_d = m_waddr[pick_idx*AW +: AW];
                    s_wdata_d = m_wdata[pick_idx*DW +: DW];
                    s_raddr_d = m_raddr[pick_idx*AW +: AW];
                    state_d   = ST_BUSY;
`ifdef SDSU_ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (s_ready) begin
                    m_rdata_d = s_rdata;
                    m_ready_d = grant_q;
                    grant_d   = '0;
                    s_valid_d = 1'b0;
                    rr_d      = rr_after;
                    state_d   = ST_DONE;
                end
`ifdef SDSU_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    m_err_d   = grant_q;
                    grant_d   = '0;
                    s_valid_d = 1'b0;
                    rr_d      = rr_after;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_q      <= '0;
            sel_q     <= '0;
            grant_q   <= '0;
            s_valid_q <= 1'b0;
            s_waddr_q <= '0;
            s_wdata_q <= '0;
            s_raddr_q <= '0;
            m_rdata_q <= '0;
            m_ready_q <= '0;
            m_err_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            s_valid_q <= s_valid_d;
            s_waddr_q <= s_waddr_d;
            s_wdata_q <= s_wdata_d;
            s_raddr_q <= s_raddr_d;
            m_rdata_q <= m_rdata_d;
            m_ready_q <= m_ready_d;
            m_err_q   <= m_err_d;
        end
    end

`ifdef SDSU_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
    assign m_err = m_err_q;
`else
    assign m_err = '0;
`endif

    assign grant   = grant_q;
    assign s_valid = s_valid_q;
    assign s_waddr = s_waddr_q;
    assign s_wdata = s_wdata_q;
    assign s_raddr = s_raddr_q;
    assign m_rdata = m_rdata_q;
    assign m_ready = m_ready_q;

endmodule

// File: tb/tb_sdsu_bus_arbiter.sv
// tb/tb_sdsu_bus_arbiter.sv - scoreboard bench for sdsu_bus_arbiter
module tb_sdsu_bus_arbiter;

    localparam int NM = 4;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NM-1:0]    m_valid;
    logic [NM*AW-1:0] m_waddr;
    logic [NM*DW-1:0] m_wdata;
    logic [NM*AW-1:0] m_raddr;
    logic [DW-1:0]    m_rdata;
    logic [NM-1:0]    m_ready;
    logic [NM-1:0]    m_err;
    logic [NM-1:0]    grant;
    logic             s_valid;
    logic [AW-1:0]    s_waddr;
    logic [DW-1:0]    s_wdata;
    logic [AW-1:0]    s_raddr;
    logic [DW-1:0]    s_rdata = '0;
    logic             s_ready = 1'b0;

    sdsu_bus_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_raddr(m_raddr),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err), .grant(grant),
        .s_valid(s_valid), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_raddr(s_raddr),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        int            cyc;
        logic [NM-1:0] onehot;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra;
    } sreq_t;

    typedef struct {
        int            cyc;
        logic [NM-1:0] onehot;
        bit            err;
        logic [DW-1:0] rdata;
    } done_t;

    sreq_t exp_s[$];
    done_t exp_d[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requester state seen by the bench model; packed onto the DUT ports.
    logic          rv  [NM];
    logic [AW-1:0] rwa [NM];
    logic [DW-1:0] rwd [NM];
    logic [AW-1:0] rra [NM];
    int            rr = 0;

    always_comb begin
        m_valid = '0;
        m_waddr = '0;
        m_wdata = '0;
        m_raddr = '0;
        for (int i = 0; i < NM; i++) begin
            m_valid[i]          = rv[i];
            m_waddr[i*AW +: AW] = rwa[i];
            m_wdata[i*DW +: DW] = rwd[i];
            m_raddr[i*AW +: AW] = rra[i];
        end
    end

    // Monitor: pops expectations when the DUT presents a request or a completion.
    sreq_t         cur;
    bit            cur_v = 1'b0;
    logic [DW-1:0] last_rdata = '0;
    done_t         d;

    always @(negedge clk) begin
        if (rst) begin
            cur_v      = 1'b0;
            last_rdata = '0;
        end else begin
            if (s_valid && !cur_v) begin
                if (exp_s.size() == 0) begin
                    check("unexpected_s_valid", 64'(s_valid), 64'(0));
                end else begin
                    cur   = exp_s.pop_front();
                    cur_v = 1'b1;
                    check("req_cycle", 64'(cyc), 64'(cur.cyc));
                end
            end
            if (s_valid && cur_v) begin
                check("grant", 64'(grant), 64'(cur.onehot));
                check("s_waddr", 64'(s_waddr), 64'(cur.wa));
                check("s_wdata", 64'(s_wdata), 64'(cur.wd));
                check("s_raddr", 64'(s_raddr), 64'(cur.ra));
            end
            if (!s_valid) begin
                cur_v = 1'b0;
                check("idle_grant", 64'(grant), 64'(0));
            end
            if (m_ready != '0 || m_err != '0) begin
                if (exp_d.size() == 0) begin
                    check("unexpected_done", 64'({m_ready, m_err}), 64'(0));
                end else begin
                    d = exp_d.pop_front();
                    check("done_cycle", 64'(cyc), 64'(d.cyc));
                    check("m_ready", 64'(m_ready), d.err ? 64'(0) : 64'(d.onehot));
                    check("m_err", 64'(m_err), d.err ? 64'(d.onehot) : 64'(0));
                    if (!d.err) last_rdata = d.rdata;
                end
            end
            check("m_rdata", 64'(m_rdata), 64'(last_rdata));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick();
        for (int k = 0; k < NM; k++) begin
            if (rv[(rr + k) % NM]) return (rr + k) % NM;
        end
        return -1;
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        rr  = 0;
    endtask

    // Called in an IDLE cycle with at least one requester; returns in the next IDLE cycle.
    task automatic run_txn(input int lat, input bit hold, input bit mut, input bit tmo);
        int    w;
        sreq_t s;
        done_t e;
        w = pick();
        s.cyc = cyc + 1; s.onehot = NM'(1) << w;
        s.wa = rwa[w]; s.wd = rwd[w]; s.ra = rra[w];
        exp_s.push_back(s);
        tick();
        if (tmo) begin
            e.cyc = cyc + TO; e.onehot = NM'(1) << w; e.err = 1'b1; e.rdata = '0;
            exp_d.push_back(e);
            s_rdata = $urandom;
            repeat (TO) tick();
        end else begin
            for (int i = 0; i < lat; i++) begin
                if (mut) begin
                    rwa[w] = AW'($urandom); rwd[w] = $urandom; rra[w] = AW'($urandom);
                    if ($urandom_range(0, 3) == 0) rv[w] = 1'b0;
                    if ($urandom_range(0, 2) == 0) rv[$urandom_range(0, NM-1)] = 1'b1;
                end
                tick();
            end
            s_ready = 1'b1;
            s_rdata = $urandom;
            e.cyc = cyc + 1; e.onehot = NM'(1) << w; e.err = 1'b0; e.rdata = s_rdata;
            exp_d.push_back(e);
            tick();
        end
        s_ready = 1'($urandom);
        s_rdata = $urandom;
        if (!hold) rv[w] = 1'b0;
        rr = (w + 1) % NM;
        tick();
        s_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NM; i++) begin
            rv[i] = 1'b0; rwa[i] = '0; rwd[i] = '0; rra[i] = '0;
        end
        do_reset(2);
        check("rst_s_valid", 64'(s_valid), 64'(0));
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_m_ready", 64'(m_ready), 64'(0));
        check("rst_m_err", 64'(m_err), 64'(0));
        check("rst_m_rdata", 64'(m_rdata), 64'(0));
        check("rst_s_addr", 64'({s_waddr, s_raddr}), 64'(0));
        check("rst_s_wdata", 64'(s_wdata), 64'(0));
        repeat (5) tick();
        check("idle_s_valid", 64'(s_valid), 64'(0));

        rv[1] = 1'b1; rwa[1] = 5'd1; rwd[1] = 32'd12345; rra[1] = 5'd16;
        run_txn(2, 1'b0, 1'b0, 1'b0);

        do_reset(1);
        for (int i = 0; i < NM; i++) begin
            rv[i] = 1'b1; rwa[i] = AW'(i + 3); rwd[i] = 32'(i * 111); rra[i] = AW'(i + 20);
        end
        for (int t = 0; t < 5; t++) run_txn(1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < NM; i++) rv[i] = 1'b0;
        tick();

        rv[2] = 1'b1; rwa[2] = 5'd7; rwd[2] = 32'd999; rra[2] = 5'd9;
        exp_s.push_back('{cyc + 1, NM'(4), 5'd7, 32'd999, 5'd9});
        tick();
        rwa[2] = 5'd2; rwd[2] = 32'd54321;
        tick();
        tick();
        s_ready = 1'b1; s_rdata = 32'hCAFE_0001;
        exp_d.push_back('{cyc + 1, NM'(4), 1'b0, 32'hCAFE_0001});
        tick();
        s_ready = 1'b0; rv[2] = 1'b0; rr = 3;
        tick();

        rv[1] = 1'b1; rwa[1] = 5'd11; rwd[1] = 32'd42; rra[1] = 5'd12;
        exp_s.push_back('{cyc + 1, NM'(2), 5'd11, 32'd42, 5'd12});
        tick();
        tick();
        rv[1] = 1'b0;
        do_reset(1);
        check("abort_s_valid", 64'(s_valid), 64'(0));
        check("abort_grant", 64'(grant), 64'(0));
        check("abort_m_ready", 64'(m_ready), 64'(0));
        tick();
        rv[0] = 1'b1; rv[3] = 1'b1;
        run_txn(1, 1'b0, 1'b0, 1'b0);
        run_txn(0, 1'b0, 1'b0, 1'b0);

`ifdef SDSU_ARB_TIMEOUT_EN
        rv[2] = 1'b1; rwd[2] = 32'h1234_5678;
        run_txn(0, 1'b0, 1'b0, 1'b1);
        rv[0] = 1'b1; rv[2] = 1'b1;
        run_txn(1, 1'b0, 1'b0, 1'b0);
        run_txn(1, 1'b0, 1'b0, 1'b0);
`endif

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int i = 0; i < NM; i++) rv[i] = 1'b0;
                repeat (2) tick();
            end
            for (int i = 0; i < NM; i++) begin
                if (!rv[i] && $urandom_range(0, 9) < 4) begin
                    rv[i] = 1'b1; rwa[i] = AW'($urandom); rwd[i] = $urandom; rra[i] = AW'($urandom);
                end
            end
            if (pick() < 0) begin
                rv[$urandom_range(0, NM-1)] = 1'b1;
            end
            run_txn($urandom_range(0, 3), $urandom_range(0, 3) == 0, 1'b1, 1'b0);
        end

        for (int i = 0; i < NM; i++) rv[i] = 1'b0;
        repeat (4) tick();
        check("exp_s_drained", 64'(exp_s.size()), 64'(0));
        check("exp_d_drained", 64'(exp_d.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
